shift_add_multiplier_param: RTL and testbench

SHIFT_ADD_MULTIPLIER_PARAM -- requirements
Module: shift_add_multiplier_param

---
 rtl/shift_add_multiplier_param_if.sv | 23 ++
 rtl/shift_add_multiplier_param.sv | 100 ++++++++++
 tb/tb_shift_add_multiplier_param.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_param_if.sv
// Request/result bundle for shift_add_multiplier_param.
// master drives operands and start; slave returns product, busy, done.
interface shift_add_multiplier_param_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;
    logic                 done;

    modport master (
        output start, signed_mode, A, B,
        input  product, busy, done
    );

    modport slave (
        input  start, signed_mode, A, B,
        output product, busy, done
    );
endinterface

// File: rtl/shift_add_multiplier_param.sv
// Iterative shift-and-add multiplier, signed or unsigned operands.
// Define SHIFT_ADD_MUL_EARLY_TERM_EN to stop once the multiplier runs out of set bits.
module shift_add_multiplier_param #(
    parameter int WIDTH = 32
) (
    input logic                  clk,
    input logic                  rst,
    shift_add_multiplier_param_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    state_t               state_n;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplr;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        count;
    logic                 sign_neg;
    logic [2*WIDTH-1:0]   product_q;
    logic                 done_q;

    logic                 accept;
    logic                 last;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   result;

    assign accept = bus.start && (state != RUN);

    // Negating the most negative value wraps to 2^(WIDTH-1), which is
    // exactly the right unsigned magnitude.
    assign a_mag = (bus.signed_mode && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign b_mag = (bus.signed_mode && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    assign result = sign_neg ? -acc : acc;

`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
    assign last = (mplr[WIDTH-1:1] == '0) || (count == CW'(WIDTH - 1));
`else
    assign last = (count == CW'(WIDTH - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept) state_n = RUN;
            RUN:     if (last) state_n = DONE;
            DONE:    state_n = accept ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand     <= '0;
            mplr      <= '0;
            acc       <= '0;
            count     <= '0;
            sign_neg  <= 1'b0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                mcand    <= {{WIDTH{1'b0}}, a_mag};
                mplr     <= b_mag;
                acc      <= '0;
                count    <= '0;
                sign_neg <= bus.signed_mode && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            end else if (state == RUN) begin
                if (mplr[0]) begin
                    acc <= acc + mcand;
                end
                mcand <= mcand << 1;
                mplr  <= mplr >> 1;
                count <= count + CW'(1);
            end
            // The accumulator still holds the finished sum here even if a
            // new operation is accepted on this same edge.
            if (state == DONE) begin
                product_q <= result;
                done_q    <= 1'b1;
            end
        end
    end

    assign bus.product = product_q;
    assign bus.busy    = (state == RUN);
    assign bus.done    = done_q;
endmodule

// File: tb/tb_shift_add_multiplier_param.sv
// Bench for shift_add_multiplier_param: vector table, random ops vs
// arithmetic model, hold/abort/back-to-back sequences at WIDTH 8 and 32.
module tb_shift_add_multiplier_param;
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    shift_add_multiplier_param_if #(.WIDTH(8))  if8 ();
    shift_add_multiplier_param_if #(.WIDTH(32)) if32 ();

    shift_add_multiplier_param #(.WIDTH(8)) u8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    shift_add_multiplier_param #(.WIDTH(32)) u32 (
        .clk (clk),
        .rst (rst),
        .bus (if32)
    );

    typedef struct {
        logic        sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_prod(logic sm, logic [7:0] a,
                                             logic [7:0] b);
        longint x;
        longint y;
        x = sm ? longint'($signed(a)) : longint'({56'b0, a});
        y = sm ? longint'($signed(b)) : longint'({56'b0, b});
        return 16'(x * y);
    endfunction

    // Edges from acceptance until done is visible.
    function automatic int ref_lat(logic sm, logic [7:0] b);
        int m;
        int n;
        if (!EARLY) return 9;
        m = (sm && b[7]) ? 256 - int'(b) : int'(b);
        n = 0;
        while (m > 0) begin
            n++;
            m = m >> 1;
        end
        if (n == 0) n = 1;
        return n + 1;
    endfunction

    task automatic do_mul(input string name, input logic sm,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp);
        int cyc;
        int busy_cnt;
        int lat;
        @(negedge clk);
        if8.start       = 1'b1;
        if8.signed_mode = sm;
        if8.A           = a;
        if8.B           = b;
        @(posedge clk);
        #1 if8.start = 1'b0;
        cyc      = 0;
        busy_cnt = 0;
        while (!if8.done && cyc < 100) begin
            if (if8.busy) busy_cnt++;
            @(posedge clk);
            cyc++;
            #1;
        end
        lat = ref_lat(sm, b);
        chk({name, "_lat"}, 64'(cyc), 64'(lat));
        chk({name, "_busy"}, 64'(busy_cnt), 64'(lat - 1));
        chk({name, "_prod"}, 64'(if8.product), 64'(exp));
        @(posedge clk);
        #1;
        chk({name, "_pulse"}, 64'(if8.done), 64'd0);
        chk({name, "_hold"}, 64'(if8.product), 64'(exp));
    endtask

    initial begin
        int cyc;
        int dones;
        logic       sm;
        logic [7:0] a;
        logic [7:0] b;

        tbl[0] = '{1'b0, 8'd255, 8'd255, 16'hFE01};
        tbl[1] = '{1'b1, 8'h80,  8'h80,  16'h4000};
        tbl[2] = '{1'b1, 8'hFD,  8'd5,   16'hFFF1};
        tbl[3] = '{1'b0, 8'd10,  8'd3,   16'd30};
        tbl[4] = '{1'b0, 8'd0,   8'd0,   16'd0};
        tbl[5] = '{1'b1, 8'd127, 8'h80,  16'hC080};
        tbl[6] = '{1'b1, 8'd1,   8'hFF,  16'hFFFF};
        tbl[7] = '{1'b0, 8'h80,  8'h80,  16'h4000};

        if8.start = 1'b0;  if8.signed_mode = 1'b0;
        if8.A = '0;        if8.B = '0;
        if32.start = 1'b0; if32.signed_mode = 1'b0;
        if32.A = '0;       if32.B = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_prod", 64'(if8.product), 64'd0);
        chk("rst_busy", 64'(if8.busy), 64'd0);
        chk("rst_done", 64'(if8.done), 64'd0);
        chk("rst_prod32", if32.product, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_mul($sformatf("vec%0d", i), tbl[i].sm, tbl[i].a, tbl[i].b,
                   tbl[i].exp);
        end

        for (int i = 0; i < 40; i++) begin
            sm = 1'($urandom);
            a  = 8'($urandom);
            b  = (i % 5 == 0) ? 8'h80 : 8'($urandom);
            if (i % 7 == 0) b = 8'($urandom_range(0, 3));
            do_mul($sformatf("rnd%0d", i), sm, a, b, ref_prod(sm, a, b));
        end

        // start held during RUN with new operands must be ignored
        @(negedge clk);
        if8.start = 1'b1; if8.signed_mode = 1'b0;
        if8.A = 8'd7;     if8.B = 8'd9;
        @(posedge clk);
        #1 if8.A = 8'd1;  if8.B = 8'd1;
        cyc = 0;
        dones = 0;
        while (cyc < 30) begin
            if (!if8.busy) if8.start = 1'b0;
            if (if8.done) begin
                dones++;
                chk("hold_prod", 64'(if8.product), 64'd63);
            end
            @(posedge clk);
            cyc++;
            #1;
        end
        chk("hold_dones", 64'(dones), 64'd1);

        // reset four cycles into RUN, with start also asserted
        @(negedge clk);
        if8.start = 1'b1; if8.A = 8'd5; if8.B = 8'd5;
        @(posedge clk);
        #1 if8.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1; if8.start = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; if8.start = 1'b0;
        chk("abort_prod", 64'(if8.product), 64'd0);
        chk("abort_busy", 64'(if8.busy), 64'd0);
        chk("abort_done", 64'(if8.done), 64'd0);
        dones = 0;
        repeat (12) begin
            @(posedge clk);
            #1 if (if8.done) dones++;
        end
        chk("abort_nodone", 64'(dones), 64'd0);
        chk("abort_idle", 64'(if8.busy), 64'd0);
        do_mul("after_abort", 1'b0, 8'd2, 8'd3, 16'd6);

        // back-to-back at WIDTH 32: second start lands in the DONE state
        @(negedge clk);
        if32.start = 1'b1; if32.A = 32'hFFFF_FFFF; if32.B = 32'd2;
        @(posedge clk);
        #1 if32.start = 1'b0;
        cyc = 0;
        while (if32.busy && cyc < 100) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        chk("b2b_first_run", 64'(cyc < 100), 64'd1);
        if32.start = 1'b1; if32.A = '0; if32.B = '0;
        @(posedge clk);
        #1 if32.start = 1'b0;
        chk("b2b_done1", 64'(if32.done), 64'd1);
        chk("b2b_prod1", if32.product, 64'h1_FFFF_FFFE);
        chk("b2b_nobubble", 64'(if32.busy), 64'd1);
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            #1;
        end while (!if32.done && cyc < 100);
        chk("b2b_lat", 64'(cyc), EARLY ? 64'd2 : 64'd33);
        chk("b2b_prod2", if32.product, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
